ext_mem_ctrl: RTL and testbench
===============================

# ext_mem_ctrl

Host-side initiator for the CPU's external memory ports: drives the instruction-memory and data-memory external port groups that the CPU exposes as a responder. Accepts a word stream, loads IMEM_WORDS instructions and then DMEM_WORDS data words. Runs the CPU by asserting its enable for RUN_CYCLES cycles, then streams the data memory back out. Sits between the testbench or host link and the cpu top.

## Interface
- IMEM_WORDS, 128, number of 32-bit instruction words loaded (≥1)
- DMEM_WORDS, 128, number of 64-bit data words loaded and dumped (≥1)
- RUN_CYCLES, 1000, cycles cpu_en is held high (≥1)
- clk  in  1  single clock, all logic rising-edge
- arst  in  1  reset, asynchronous, active-high
- start  in  1  begin a load/run/dump sequence; sampled only in IDLE
- s_valid  in  1  input word valid
- s_ready  out  1  input word ready
- s_data  in  64  input word; [31:0] used during instruction load
- m_valid  out  1  dump word valid
- m_ready  in  1  dump word ready
- m_data  out  64  dump word
- cpu_en  out  1  drives CPU enable
- addr_ext  out  64  IMEM external byte address
- wen_ext  out  1  IMEM external write enable
- ren_ext  out  1  IMEM external read enable, tied 0
- wdata_ext  out  32  IMEM external write data
- addr_ext_2  out  64  DMEM external byte address
- wen_ext_2  out  1  DMEM external write enable
- ren_ext_2  out  1  DMEM external read enable
- wdata_ext_2  out  64  DMEM external write data
- rdata_ext_2  in  64  DMEM external read data, valid the cycle after ren_ext_2
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE

## Operation
- States: IDLE, LOAD_I, LOAD_D, RUN, DUMP_REQ, DUMP_CAP, DUMP_OUT, DONE.
- IDLE: start=1 → LOAD_I, word counter cleared. start outside IDLE or DONE is ignored.
- LOAD_I: s_ready=1. Accept = s_valid&&s_ready. Word i goes to byte address 4*i with data s_data[31:0]. After accepting word IMEM_WORDS-1 → LOAD_D, counter cleared.
- LOAD_D: s_ready=1. Word j goes to byte address 8*j with data s_data. After accepting word DMEM_WORDS-1 → RUN.
- RUN: cpu_en=1 for exactly RUN_CYCLES cycles, then → DUMP_REQ with counter cleared.
- DUMP_REQ: ren_ext_2=1, addr_ext_2=8*k → DUMP_CAP.
- DUMP_CAP: latch rdata_ext_2 into m_data → DUMP_OUT.
- DUMP_OUT: m_valid=1, m_data held stable until m_ready. On handshake: k=DMEM_WORDS-1 → DONE, else k+1 → DUMP_REQ.
- DONE: start=1 → LOAD_I, starting a new sequence. There is no other exit except reset.
- Counters are sized $clog2(max param + 1). Addresses are zero-extended to 64 bits.
- Reset (any time, including mid-load or mid-dump): state=IDLE, counters 0. Every output is 0 except s_ready, which is also 0. Partially written memory is not cleaned.

## Timing
- Writes are registered. wen_ext/wen_ext_2 pulse high for exactly one cycle, the cycle after the accept, with matching registered addr/data.
- Back-to-back accepts give back-to-back write pulses. Throughput is 1 word/cycle.
- The write for the last instruction word occurs in the first LOAD_D cycle.
- The write for the last data word occurs in the first RUN cycle. That is one cycle before the CPU observes cpu_en, which is registered.
- cpu_en rises the cycle after entering RUN and is high for exactly RUN_CYCLES consecutive cycles.
- Dump latency is 3 cycles minimum per word (REQ, CAP, OUT) with m_ready=1.
- m_valid never drops without a handshake.
- s_ready is 0 outside LOAD_I/LOAD_D. s_valid there is ignored and never accepted.

## Configuration
- EXT_MEM_READBACK_EN defined: dump states are present as described.
- Not defined: RUN → DONE directly. m_valid, m_data and ren_ext_2 are tied 0, and DUMP_* states are not generated.

## Structure
- Package ext_mem_ctrl_pkg contains:
  - state enum typedef;
  - IMEM_STRIDE=4 and DMEM_STRIDE=8 byte-stride constants.
- One sub-module, ext_word_counter: a parameterised up-counter with clear, increment and terminal-count flag. It is instantiated once and shared by the load, run and dump phases.

## Test plan
- Reset mid-LOAD_I after 3 words: all outputs 0, state IDLE, and start restarts at addr_ext=0.
- IMEM_WORDS=4, DMEM_WORDS=2, words 0x11..0x16 with s_valid continuous:
  - wen_ext pulses at addr 0,4,8,12 with data 0x11..0x14;
  - wen_ext_2 pulses at addr 0,8 with 0x15,0x16.
- s_valid toggling 1,0,1,0: one write pulse per accepted word and none on idle cycles; addresses increment only on accept.
- RUN_CYCLES=5: cpu_en high for exactly 5 cycles, then ren_ext_2 at addr 0.
- Dump with DMEM returning 0xA, 0xB and m_ready low for 4 cycles on word 0: m_data=0xA held stable, then 0xB, then done=1.
- EXT_MEM_READBACK_EN undefined: done=1 the cycle after cpu_en falls; m_valid and ren_ext_2 are never 1.

Source files
------------

// File: rtl/ext_mem_ctrl_pkg.sv
// ext_mem_ctrl_pkg: shared state encoding and address strides for ext_mem_ctrl.
// Revision: 1.0
`default_nettype none

package ext_mem_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_I   = 3'd1,
    ST_LOAD_D   = 3'd2,
    ST_RUN      = 3'd3,
    ST_DUMP_REQ = 3'd4,
    ST_DUMP_CAP = 3'd5,
    ST_DUMP_OUT = 3'd6,
    ST_DONE     = 3'd7
  } state_e;

  localparam int IMEM_STRIDE = 4;
  localparam int DMEM_STRIDE = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ext_word_counter.sv
// ext_word_counter: up-counter with synchronous clear, increment and a
// terminal-count flag against a run-time terminal value. Revision: 1.0
`default_nettype none

module ext_word_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic [WIDTH-1:0] i_term,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == i_term);

endmodule

`default_nettype wire

// File: rtl/ext_mem_ctrl.sv
// ext_mem_ctrl: loads IMEM/DMEM through the CPU external ports, runs the CPU,
// then dumps DMEM. Readback dump enabled by EXT_MEM_READBACK_EN. Revision: 1.0
`default_nettype none

module ext_mem_ctrl
  import ext_mem_ctrl_pkg::*;
#(
  parameter int IMEM_WORDS = 128,
  parameter int DMEM_WORDS = 128,
  parameter int RUN_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        start,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [63:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [63:0] m_data,
  output logic        cpu_en,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  input  logic [63:0] rdata_ext_2,
  output logic        busy,
  output logic        done
);

  localparam int CW = $clog2(max3(IMEM_WORDS, DMEM_WORDS, RUN_CYCLES) + 1);

  state_e        r_state;
  state_e        w_next;
  logic          r_cpu_en;
  logic          r_wen_i;
  logic          r_wen_d;
  logic [63:0]   r_addr_i;
  logic [63:0]   r_addr_d;
  logic [31:0]   r_wdata_i;
  logic [63:0]   r_wdata_d;
  logic          w_accept;
  logic          w_clr;
  logic          w_inc;
  logic          w_tc;
  logic [CW-1:0] w_cnt;
  logic [CW-1:0] w_term;
  logic [63:0]   w_cnt64;

  // One counter serves every phase; only its terminal value changes with state.
  ext_word_counter #(
    .WIDTH (CW)
  ) u_cnt (
    .clk     (clk),
    .arst    (arst),
    .i_clr   (w_clr),
    .i_inc   (w_inc),
    .i_term  (w_term),
    .o_count (w_cnt),
    .o_tc    (w_tc)
  );

  assign w_cnt64  = 64'(w_cnt);
  assign s_ready  = (r_state == ST_LOAD_I) || (r_state == ST_LOAD_D);
  assign w_accept = s_valid && s_ready;

  always_comb begin
    w_term = CW'(DMEM_WORDS - 1);
    case (r_state)
      ST_LOAD_I: w_term = CW'(IMEM_WORDS - 1);
      ST_RUN:    w_term = CW'(RUN_CYCLES - 1);
      default:   w_term = CW'(DMEM_WORDS - 1);
    endcase
  end

  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    w_inc  = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_next = ST_LOAD_I;
          w_clr  = 1'b1;
        end
      end
      ST_LOAD_I: begin
        if (w_accept) begin
          if (w_tc) begin
            w_next = ST_LOAD_D;
            w_clr  = 1'b1;
          end else begin
            w_inc = 1'b1;
          end
        end
      end
      ST_LOAD_D: begin
        if (w_accept) begin
          if (w_tc) begin
            w_next = ST_RUN;
            w_clr  = 1'b1;
          end else begin
            w_inc = 1'b1;
          end
        end
      end
      // Counting starts once cpu_en is visible, so it stays high RUN_CYCLES cycles.
      ST_RUN: begin
        if (r_cpu_en) begin
          if (w_tc) begin
`ifdef EXT_MEM_READBACK_EN
            w_next = ST_DUMP_REQ;
`else
            w_next = ST_DONE;
`endif
            w_clr  = 1'b1;
          end else begin
            w_inc = 1'b1;
          end
        end
      end
`ifdef EXT_MEM_READBACK_EN
      ST_DUMP_REQ: w_next = ST_DUMP_CAP;
      ST_DUMP_CAP: w_next = ST_DUMP_OUT;
      ST_DUMP_OUT: begin
        if (m_ready) begin
          if (w_tc) begin
            w_next = ST_DONE;
          end else begin
            w_next = ST_DUMP_REQ;
            w_inc  = 1'b1;
          end
        end
      end
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state   <= ST_IDLE;
      r_cpu_en  <= 1'b0;
      r_wen_i   <= 1'b0;
      r_wen_d   <= 1'b0;
      r_addr_i  <= '0;
      r_addr_d  <= '0;
      r_wdata_i <= '0;
      r_wdata_d <= '0;
    end else begin
      r_state  <= w_next;
      r_cpu_en <= (r_state == ST_RUN) && !(r_cpu_en && w_tc);
      r_wen_i  <= w_accept && (r_state == ST_LOAD_I);
      r_wen_d  <= w_accept && (r_state == ST_LOAD_D);
      if (w_accept && (r_state == ST_LOAD_I)) begin
        r_addr_i  <= w_cnt64 * 64'(IMEM_STRIDE);
        r_wdata_i <= s_data[31:0];
      end
      if (w_accept && (r_state == ST_LOAD_D)) begin
        r_addr_d  <= w_cnt64 * 64'(DMEM_STRIDE);
        r_wdata_d <= s_data;
      end
    end
  end

`ifdef EXT_MEM_READBACK_EN
  logic [63:0] r_mdata;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_mdata <= '0;
    end else if (r_state == ST_DUMP_CAP) begin
      r_mdata <= rdata_ext_2;
    end
  end

  assign m_valid    = (r_state == ST_DUMP_OUT);
  assign m_data     = r_mdata;
  assign ren_ext_2  = (r_state == ST_DUMP_REQ);
  assign addr_ext_2 = (r_state == ST_DUMP_REQ) ? (w_cnt64 * 64'(DMEM_STRIDE)) : r_addr_d;
`else
  logic w_unused;
  assign w_unused   = ^{rdata_ext_2, m_ready};
  assign m_valid    = 1'b0;
  assign m_data     = '0;
  assign ren_ext_2  = 1'b0;
  assign addr_ext_2 = r_addr_d;
`endif

  assign cpu_en      = r_cpu_en;
  assign addr_ext    = r_addr_i;
  assign wen_ext     = r_wen_i;
  assign ren_ext     = 1'b0;
  assign wdata_ext   = r_wdata_i;
  assign wen_ext_2   = r_wen_d;
  assign wdata_ext_2 = r_wdata_d;
  assign busy        = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign done        = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_ext_mem_ctrl.sv
// tb_ext_mem_ctrl: scoreboard bench for ext_mem_ctrl (small IMEM/DMEM/RUN sizes).
// Revision: 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_ext_mem_ctrl;

  localparam int IW = 4;
  localparam int DW = 2;
  localparam int RC = 5;

  logic        clk = 1'b0;
  logic        arst;
  logic        start;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [63:0] m_data;
  logic        cpu_en;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [63:0] wdata_ext_2;
  logic [63:0] rdata_ext_2 = '0;
  logic        busy;
  logic        done;

  ext_mem_ctrl #(
    .IMEM_WORDS (IW),
    .DMEM_WORDS (DW),
    .RUN_CYCLES (RC)
  ) dut (
    .clk         (clk),
    .arst        (arst),
    .start       (start),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .cpu_en      (cpu_en),
    .addr_ext    (addr_ext),
    .wen_ext     (wen_ext),
    .ren_ext     (ren_ext),
    .wdata_ext   (wdata_ext),
    .addr_ext_2  (addr_ext_2),
    .wen_ext_2   (wen_ext_2),
    .ren_ext_2   (ren_ext_2),
    .wdata_ext_2 (wdata_ext_2),
    .rdata_ext_2 (rdata_ext_2),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  logic [63:0] q_ia[$];
  logic [63:0] q_id[$];
  logic [63:0] q_da[$];
  logic [63:0] q_dd[$];
  logic [63:0] q_dump[$];
  logic [63:0] dm_ret [0:1];

  int          ren_cnt     = 0;
  int          run_len     = 0;
  int          dump_idx    = 0;
  int          hold        = 0;
  logic        prev_cpu_en = 1'b0;
  logic        saw_mvalid  = 1'b0;
  logic        saw_ren     = 1'b0;
  logic [63:0] held        = '0;

  initial begin
    dm_ret[0] = 64'hA;
    dm_ret[1] = 64'hB;
  end

  // DMEM responder: data valid the cycle after a read request.
  always @(posedge clk) begin
    if (ren_ext_2) rdata_ext_2 <= dm_ret[addr_ext_2[3]];
  end

  always @(negedge clk) begin
    if (!arst) begin
      if (wen_ext) begin
        if (q_ia.size() == 0) check("imem_extra_write", 64'd1, 64'd0);
        else begin
          check("imem_addr", addr_ext, q_ia.pop_front());
          check("imem_data", {32'b0, wdata_ext}, q_id.pop_front());
        end
      end
      if (wen_ext_2) begin
        if (q_da.size() == 0) check("dmem_extra_write", 64'd1, 64'd0);
        else begin
          check("dmem_addr", addr_ext_2, q_da.pop_front());
          check("dmem_data", wdata_ext_2, q_dd.pop_front());
        end
      end
      if (cpu_en) run_len++;
      else if (prev_cpu_en) begin
        check("run_len", 64'(run_len), 64'(RC));
        run_len = 0;
`ifdef EXT_MEM_READBACK_EN
        check("ren_after_run", {63'b0, ren_ext_2}, 64'd1);
`else
        check("done_after_run", {63'b0, done}, 64'd1);
`endif
      end
      prev_cpu_en = cpu_en;
      if (ren_ext_2) saw_ren = 1'b1;
      if (m_valid) saw_mvalid = 1'b1;
`ifdef EXT_MEM_READBACK_EN
      if (ren_ext_2) begin
        check("dump_addr", addr_ext_2, 64'((ren_cnt % DW) * 8));
        q_dump.push_back(dm_ret[ren_cnt % DW]);
        ren_cnt++;
      end
      if (m_valid) begin
        if (dump_idx == 0 && hold < 4) begin
          m_ready = 1'b0;
          if (hold > 0) check("m_data_stable", m_data, held);
          held = m_data;
          hold++;
        end else begin
          m_ready = 1'b1;
        end
        if (m_ready) begin
          if (q_dump.size() == 0) check("dump_extra", 64'd1, 64'd0);
          else check("dump_data", m_data, q_dump.pop_front());
          dump_idx++;
        end
      end
`endif
    end
  end

  task automatic send(input logic [63:0] w, input bit is_d, input int idx);
    int  t  = 0;
    bit  ok = 1'b0;
    s_valid = 1'b1;
    s_data  = w;
    while (!ok && t < 20) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        if (is_d) begin
          q_da.push_back(64'(idx * 8));
          q_dd.push_back(w);
        end else begin
          q_ia.push_back(64'(idx * 4));
          q_id.push_back({32'b0, w[31:0]});
        end
      end
      @(posedge clk); #1;
      t++;
    end
    s_valid = 1'b0;
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic gap();
    s_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_seq(input bit toggle, input logic [63:0] hi, input logic [7:0] base);
    int t = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < IW; i++) begin
      send(hi | 64'(base + 8'(i)), 1'b0, i);
      if (toggle) gap();
    end
    for (int j = 0; j < DW; j++) begin
      send(hi | 64'(base + 8'(IW + j)), 1'b1, j);
      if (toggle && j != DW - 1) gap();
    end
    // Words offered outside the load phases must be ignored.
    s_valid = 1'b1;
    s_data  = '1;
    @(negedge clk);
    check("s_ready_run", {63'b0, s_ready}, 64'd0);
    while (!done && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    s_valid = 1'b0;
    check("done_seen", {63'b0, done}, 64'd1);
    check("busy_in_done", {63'b0, busy}, 64'd0);
  endtask

  initial begin
    arst    = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    arst = 1'b0;
    @(posedge clk); #1;
    check("idle_flags", {61'b0, busy, done, s_ready}, 64'd0);

    // Abort a load after three instruction words.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) send(64'(8'h21 + 8'(i)), 1'b0, i);
    @(negedge clk);
    #1;
    arst = 1'b1;
    #1;
    check("rst_outputs_zero",
          {63'b0, |{s_ready, m_valid, m_data, cpu_en, addr_ext, wen_ext, ren_ext, wdata_ext,
                    addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2, busy, done}}, 64'd0);
    check("rst_imem_q_empty", 64'(q_ia.size()), 64'd0);
    @(posedge clk); #1;
    arst = 1'b0;
    @(posedge clk); #1;

    run_seq(1'b0, 64'h0, 8'h11);
    run_seq(1'b1, 64'hABCD_0000_0000_0000, 8'h31);

    repeat (3) @(posedge clk);
    #1;
    check("imem_q_drained", 64'(q_ia.size()), 64'd0);
    check("dmem_q_drained", 64'(q_da.size()), 64'd0);
    check("ren_ext_tied", {63'b0, ren_ext}, 64'd0);
`ifdef EXT_MEM_READBACK_EN
    check("dump_q_drained", 64'(q_dump.size()), 64'd0);
    check("dump_count", 64'(dump_idx), 64'(2 * DW));
`else
    check("no_m_valid", {63'b0, saw_mvalid}, 64'd0);
    check("no_ren_ext_2", {63'b0, saw_ren}, 64'd0);
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
